depunct_ctrl: RTL

DEPUNCT_CTRL -- requirements
Module: depunct_ctrl

---
 rtl/depunct_ctrl_if.sv | 34 +++
 rtl/depunct_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/depunct_ctrl_if.sv
// Handshake bundle between the depuncture controller, its serial soft-bit source
// and the branch-metric unit that consumes the reconstructed X/Y pairs.
`timescale 1ns/1ps
interface depunct_ctrl_if #(
    parameter int SW   = 3,
    parameter int LENW = 16
);
    logic            start_i;
    logic            abort_i;
    logic [2:0]      rate_i;
    logic [LENW-1:0] frame_len_i;
    logic [SW-1:0]   in_data_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [SW-1:0]   x_o;
    logic [SW-1:0]   y_o;
    logic            x_erase_o;
    logic            y_erase_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic            busy_o;
    logic            done_o;
    logic            cfg_err_o;

    modport slave (
        input  start_i, abort_i, rate_i, frame_len_i, in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, x_o, y_o, x_erase_o, y_erase_o, out_valid_o, busy_o, done_o, cfg_err_o
    );

    modport master (
        output start_i, abort_i, rate_i, frame_len_i, in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, x_o, y_o, x_erase_o, y_erase_o, out_valid_o, busy_o, done_o, cfg_err_o
    );
endinterface

// File: rtl/depunct_ctrl.sv
// Depuncture controller: rebuilds X/Y soft-symbol pairs from a serial punctured
// stream, inserting zero-valued erasures where the puncture mask dropped a bit.
`timescale 1ns/1ps
module depunct_ctrl #(
    parameter int SW   = 3,
    parameter int LENW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    depunct_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_X = 3'd1,
        GET_Y = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [LENW-1:0] LEN_ONE = {{(LENW-1){1'b0}}, 1'b1};

    // Mask bit i is phase i; 1 = the bit was transmitted.
    function automatic logic [6:0] x_mask(input logic [2:0] rate);
        case (rate)
            3'd0:    x_mask = 7'b0000001;
            3'd1:    x_mask = 7'b0000001;
            3'd2:    x_mask = 7'b0000101;
            3'd3:    x_mask = 7'b0010101;
            3'd4:    x_mask = 7'b1010001;
            default: x_mask = 7'b0000001;
        endcase
    endfunction

    function automatic logic [6:0] y_mask(input logic [2:0] rate);
        case (rate)
            3'd0:    y_mask = 7'b0000001;
            3'd1:    y_mask = 7'b0000011;
            3'd2:    y_mask = 7'b0000011;
            3'd3:    y_mask = 7'b0001011;
            3'd4:    y_mask = 7'b0101111;
            default: y_mask = 7'b0000001;
        endcase
    endfunction

    function automatic logic [2:0] period(input logic [2:0] rate);
        case (rate)
            3'd0:    period = 3'd1;
            3'd1:    period = 3'd2;
            3'd2:    period = 3'd3;
            3'd3:    period = 3'd5;
            3'd4:    period = 3'd7;
            default: period = 3'd1;
        endcase
    endfunction

    state_t          state_r, state_s;
    logic [2:0]      rate_r, rate_s;
    logic [2:0]      phase_r, phase_s;
    logic [LENW-1:0] len_r, len_s;
    logic [LENW-1:0] cnt_r, cnt_s;
    logic [SW-1:0]   x_r, x_s;
    logic [SW-1:0]   y_r, y_s;
    logic            x_erase_r, x_erase_s;
    logic            y_erase_r, y_erase_s;
    logic            cfg_err_r, cfg_err_s;
    logic            in_ready_r, in_ready_s;
    logic            out_valid_r;
    logic            busy_r;
    logic            done_r;
    logic [6:0]      xm_r, ym_r, xm_s, ym_s;

    assign xm_r = x_mask(rate_r);
    assign ym_r = y_mask(rate_r);

    // Next-state and datapath decode; abort has priority over everything.
    always_comb begin
        state_s   = state_r;
        rate_s    = rate_r;
        phase_s   = phase_r;
        len_s     = len_r;
        cnt_s     = cnt_r;
        x_s       = x_r;
        y_s       = y_r;
        x_erase_s = x_erase_r;
        y_erase_s = y_erase_r;
        cfg_err_s = cfg_err_r;
        if (bus.abort_i) begin
            state_s   = IDLE;
            x_s       = {SW{1'b0}};
            y_s       = {SW{1'b0}};
            x_erase_s = 1'b0;
            y_erase_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_i) begin
                        // Illegal rates fall back to the unpunctured 1/2 pattern.
                        rate_s    = (bus.rate_i <= 3'd4) ? bus.rate_i : 3'd0;
                        cfg_err_s = (bus.rate_i > 3'd4);
                        len_s     = bus.frame_len_i;
                        phase_s   = 3'd0;
                        cnt_s     = {LENW{1'b0}};
                        state_s   = (bus.frame_len_i == {LENW{1'b0}}) ? DONE : GET_X;
                    end else begin
                        state_s = IDLE;
                    end
                end
                GET_X: begin
                    if (xm_r[phase_r]) begin
                        if (bus.in_valid_i) begin
                            x_s       = bus.in_data_i;
                            x_erase_s = 1'b0;
                            state_s   = GET_Y;
                        end else begin
                            state_s = GET_X;
                        end
                    end else begin
                        x_s       = {SW{1'b0}};
                        x_erase_s = 1'b1;
                        state_s   = GET_Y;
                    end
                end
                GET_Y: begin
                    if (ym_r[phase_r]) begin
                        if (bus.in_valid_i) begin
                            y_s       = bus.in_data_i;
                            y_erase_s = 1'b0;
                            state_s   = OUT;
                        end else begin
                            state_s = GET_Y;
                        end
                    end else begin
                        y_s       = {SW{1'b0}};
                        y_erase_s = 1'b1;
                        state_s   = OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready_i) begin
                        phase_s = (phase_r == (period(rate_r) - 3'd1)) ? 3'd0 : (phase_r + 3'd1);
                        cnt_s   = cnt_r + LEN_ONE;
                        state_s = (cnt_r == (len_r - LEN_ONE)) ? DONE : GET_X;
                    end else begin
                        state_s = OUT;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    assign xm_s = x_mask(rate_s);
    assign ym_s = y_mask(rate_s);

    // Ready is precomputed from the next state so it can leave the block registered.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_s == GET_X) begin
            in_ready_s = xm_s[phase_s];
        end else if (state_s == GET_Y) begin
            in_ready_s = ym_s[phase_s];
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            rate_r      <= 3'd0;
            phase_r     <= 3'd0;
            len_r       <= {LENW{1'b0}};
            cnt_r       <= {LENW{1'b0}};
            x_r         <= {SW{1'b0}};
            y_r         <= {SW{1'b0}};
            x_erase_r   <= 1'b0;
            y_erase_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rate_r      <= rate_s;
            phase_r     <= phase_s;
            len_r       <= len_s;
            cnt_r       <= cnt_s;
            x_r         <= x_s;
            y_r         <= y_s;
            x_erase_r   <= x_erase_s;
            y_erase_r   <= y_erase_s;
            cfg_err_r   <= cfg_err_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= (state_s == OUT);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.x_o         = x_r;
    assign bus.y_o         = y_r;
    assign bus.x_erase_o   = x_erase_r;
    assign bus.y_erase_o   = y_erase_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.cfg_err_o   = cfg_err_r;
endmodule
